// File: rtl/uart_frame_pkg.sv
// Shared constants, FSM encoding and frame-byte helpers for the UART frame sender.
// A buffered entry is {ch[1:0], sample[11:0]}; a frame is header, two payload bytes, checksum.
package uart_frame_pkg;

  localparam logic [7:0]  HEADER_DEFAULT = 8'hAA;
  localparam int unsigned FRAME_LEN      = 4;
  localparam int unsigned ENTRY_W        = 14;
  localparam logic [1:0]  LAST_IDX       = 2'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } fsm_state_e;

  function automatic logic [7:0] frame_checksum(input logic [7:0] b0,
                                                input logic [7:0] b1,
                                                input logic [7:0] b2);
    return b0 ^ b1 ^ b2;
  endfunction

  function automatic logic [7:0] frame_byte(input logic [7:0]         hdr,
                                            input logic [ENTRY_W-1:0] entry,
                                            input logic [1:0]         idx);
    logic [7:0] b1;
    logic [7:0] b2;
    b1 = {entry[13:12], 2'b00, entry[11:8]};
    b2 = entry[7:0];
    case (idx)
      2'd0:    return hdr;
      2'd1:    return b1;
      2'd2:    return b2;
      2'd3:    return frame_checksum(hdr, b1, b2);
      default: return hdr;
    endcase
  endfunction

endpackage

// File: rtl/uart_frame_sender_fifo.sv
// Synchronous FIFO (power-of-two depth) with registered occupancy; full/empty decode
// from that registered count, so an entry written this cycle is not visible until the next.
module sync_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_wdata,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == {CW{1'b0}});
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // storage array; contents are don't-care while empty, so no reset
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // pointers wrap naturally at the power-of-two depth
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_frame_sender.sv
// Buffers {channel, ADC sample} entries and sends each as a 4-byte frame to a byte UART,
// one byte per send_en pulse, advancing on the transmitter's tx_done pulse.
module uart_frame_sender
  import uart_frame_pkg::*;
#(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] HEADER     = HEADER_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [1:0]  s_ch,
  input  logic [11:0] s_sample,
  output logic [7:0]  tx_data,
  output logic        send_en,
  input  logic        tx_done,
  output logic        busy
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  fsm_state_e         r_state;
  fsm_state_e         w_next_state;
  logic [1:0]         r_idx;
  logic [1:0]         w_next_idx;
  logic [ENTRY_W-1:0] r_entry;
  logic [ENTRY_W-1:0] w_next_entry;
  logic               r_send_en;
  logic               w_next_send_en;
  logic [7:0]         r_tx_data;
  logic [7:0]         w_next_tx_data;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [ENTRY_W-1:0] w_rdata;
  logic [CW-1:0]      w_count;

  assign w_push = s_valid & ~w_full;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (Clk),
    .i_rst_n (Reset_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({s_ch, s_sample}),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // next-state and next-output logic; tx_done only matters in WAIT
  always_comb begin
    w_next_state   = r_state;
    w_next_idx     = r_idx;
    w_next_entry   = r_entry;
    w_next_send_en = 1'b0;
    w_next_tx_data = r_tx_data;
    w_pop          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_entry = w_rdata;
          w_next_idx   = 2'd0;
          w_next_state = ST_SEND;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_SEND: begin
        w_next_send_en = 1'b1;
        w_next_tx_data = frame_byte(HEADER, r_entry, r_idx);
        w_next_state   = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_done) begin
          if (r_idx == LAST_IDX) begin
            w_next_state = ST_IDLE;
          end else begin
            w_next_idx   = r_idx + 2'd1;
            w_next_state = ST_SEND;
          end
        end else begin
          w_next_state = ST_WAIT;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_idx   = 2'd0;
      end
    endcase
  end

  // state, frame latch and registered UART-facing outputs
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state   <= ST_IDLE;
      r_idx     <= 2'd0;
      r_entry   <= {ENTRY_W{1'b0}};
      r_send_en <= 1'b0;
      r_tx_data <= 8'h00;
    end else begin
      r_state   <= w_next_state;
      r_idx     <= w_next_idx;
      r_entry   <= w_next_entry;
      r_send_en <= w_next_send_en;
      r_tx_data <= w_next_tx_data;
    end
  end

  assign send_en = r_send_en;
  assign tx_data = r_tx_data;
  assign s_ready = ~w_full;
  assign busy    = (r_state != ST_IDLE) | (w_count != CW'(0));

endmodule

// File: doc/uart_frame_sender.md
UART_FRAME_SENDER -- requirements
Module: uart_frame_sender

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, sample buffer depth (power of two, >=2).
REQ-002 SHALL have parameter HEADER, default 8'hAA, first byte of every frame.
REQ-003 SHALL have port Clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port s_valid  input  1  sample offered by acquisition side.
REQ-006 SHALL have port s_ready  output  1  buffer can accept; equals !fifo_full.
REQ-007 SHALL have port s_ch  input  2  channel number of offered sample.
REQ-008 SHALL have port s_sample  input  12  ADC sample value.
REQ-009 SHALL have port tx_data  output  8  byte to UART transmitter Data input.
REQ-010 SHALL have port send_en  output  1  one-cycle start pulse to UART transmitter.
REQ-011 SHALL have port tx_done  input  1  one-cycle byte-complete pulse from UART transmitter.
REQ-012 SHALL have port busy  output  1  high while FSM not IDLE or FIFO non-empty.

Function
REQ-013 SHALL accept a sample on a rising edge where s_valid && s_ready, writing {s_ch, s_sample} into the FIFO.
REQ-014 SHALL deliver FIFO entries strictly in acceptance order; pointers wrap modulo FIFO_DEPTH; occupancy counts 0..FIFO_DEPTH.
REQ-015 SHALL frame each sample as 4 bytes: B0=HEADER, B1={ch[1:0],2'b00,sample[11:8]}, B2=sample[7:0], B3=B0^B1^B2.
REQ-016 SHALL run FSM IDLE -> SEND -> WAIT: IDLE pops FIFO when non-empty, latches frame, byte index 0, goes SEND; SEND asserts send_en for exactly one cycle, goes WAIT; WAIT on tx_done goes SEND with index+1, or IDLE if index==3.
REQ-017 SHALL register send_en and tx_data; tx_data SHALL be valid in the send_en cycle and held stable until the matching tx_done.
REQ-018 SHALL assert first send_en of a frame in the 2nd cycle after acceptance when FIFO empty and FSM IDLE (latency 2).
REQ-019 SHALL assert next send_en in the cycle after tx_done (one-cycle gap); back-to-back frames SHALL add one IDLE cycle between B3 tx_done and next B0 send_en.
REQ-020 SHALL ignore tx_done in IDLE and SEND states.
REQ-021 SHALL never push when full (s_ready low); a pop and push in the same cycle SHALL keep occupancy unchanged.
REQ-022 SHALL not pop an entry written in the same cycle (empty flag registered).

Reset
REQ-023 SHALL on Reset_n low, asynchronously: FSM IDLE, FIFO empty (pointers/occupancy 0), byte index 0, send_en 0, tx_data 8'h00, busy 0, s_ready 1.
REQ-024 SHALL on reset mid-frame abandon the frame and all buffered samples; no send_en until a new sample is accepted after release.

Structure
REQ-025 SHALL place HEADER default, frame length constant (4), and FSM state encoding in shared package uart_frame_pkg.
REQ-026 SHALL implement buffering in one sub-module sync_fifo (width 14, depth FIFO_DEPTH, full/empty/occupancy outputs).

Verification
REQ-027 SHALL cover: single sample ch=2, sample=12'h5A3, UART model answering tx_done -> bytes AA, 85, A3, 8C in order, one send_en each.
REQ-028 SHALL cover: tx_done held low, s_valid held high 12 cycles -> exactly FIFO_DEPTH+1=9 accepted, s_ready low thereafter, single send_en outstanding.
REQ-029 SHALL cover: 20 samples with ramping values, random tx_done delays -> 80 bytes, samples reconstructed in order, checksums correct, pointer wrap exercised.
REQ-030 SHALL cover: Reset_n pulsed low after B1 tx_done with 3 entries queued -> send_en/tx_data 0 immediately, busy 0, no further bytes until new sample.
REQ-031 SHALL cover: spurious tx_done pulse in IDLE and in SEND -> byte index and output sequence unaffected.
REQ-032 SHALL cover: latency check, sample accepted at edge N into empty idle block -> send_en high at edge N+2, tx_data=8'hAA.
